// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result handshake bundle for pipelined_prefix_adder.
// The master side is the upstream producer plus downstream consumer; the slave side is the adder.
interface pipelined_prefix_adder_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_prefix_adder.sv
// Pipelined ADD/SUB/ADC/SBB: one SEG-bit prefix-carry segment resolved per stage, with the
// inter-segment carry registered and operands/partial sums skewed so a whole beat exits together.
module pipelined_prefix_adder #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input logic                     clk,
  input logic                     rst,
  pipelined_prefix_adder_if.slave io
);

  localparam int STAGES = (SEG < 1) ? 1 : WIDTH / SEG;
  localparam int LAST   = STAGES - 1;
  localparam int MSB    = WIDTH - 1;

  generate
    if (SEG < 1) begin : g_bad_seg
      $error("pipelined_prefix_adder: SEG must be at least 1");
    end else if ((WIDTH % SEG) != 0) begin : g_bad_width
      $error("pipelined_prefix_adder: WIDTH must be a multiple of SEG");
    end
  endgenerate

  // Kogge-Stone carry tree over one segment; carry-in is folded into bit 0's generate.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] x,
                                           input logic [SEG-1:0] y,
                                           input logic           ci);
    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG-1:0] pg;
    logic [SEG-1:0] g_n;
    logic [SEG-1:0] pg_n;
    logic [SEG:0]   c;
    p    = x ^ y;
    g    = x & y;
    g[0] = g[0] | (p[0] & ci);
    pg   = p;
    for (int d = 1; d < SEG; d = d * 2) begin
      g_n  = g;
      pg_n = pg;
      for (int i = d; i < SEG; i++) begin
        g_n[i]  = g[i] | (pg[i] & g[i-d]);
        pg_n[i] = pg[i] & pg[i-d];
      end
      g  = g_n;
      pg = pg_n;
    end
    c = {g, ci};
    return {c[SEG], p ^ c[SEG-1:0]};
  endfunction

  logic [WIDTH-1:0]  a_q     [STAGES];
  logic [WIDTH-1:0]  a_d     [STAGES];
  logic [WIDTH-1:0]  b_q     [STAGES];
  logic [WIDTH-1:0]  b_d     [STAGES];
  logic [WIDTH-1:0]  sum_q   [STAGES];
  logic [WIDTH-1:0]  sum_d   [STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] carry_d;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic              zero_q;
  logic              zero_d;

  logic [WIDTH-1:0]  a_src   [STAGES];
  logic [WIDTH-1:0]  b_src   [STAGES];
  logic [WIDTH-1:0]  s_src   [STAGES];
  logic [STAGES-1:0] c_src;
  logic [SEG:0]      seg_res [STAGES];
  logic [WIDTH-1:0]  b_in;
  logic              c_in;
  logic              adv;

  assign adv = !valid_q[LAST] || io.out_ready;

  always_comb begin
    b_in = io.op[0] ? ~io.b : io.b;
    case (io.op)
      2'b00:   c_in = 1'b0;
      2'b01:   c_in = 1'b1;
      default: c_in = io.cin;
    endcase

    a_src[0]   = io.a;
    b_src[0]   = b_in;
    s_src[0]   = '0;
    c_src[0]   = c_in;
    valid_d[0] = io.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      s_src[k]   = sum_q[k-1];
      c_src[k]   = carry_q[k-1];
      valid_d[k] = valid_q[k-1];
    end

    // Stage k owns bits [k*SEG +: SEG]; lower bits ride along already resolved.
    for (int k = 0; k < STAGES; k++) begin
      seg_res[k] = seg_add(a_src[k][k*SEG +: SEG], b_src[k][k*SEG +: SEG], c_src[k]);
      a_d[k]     = a_src[k];
      b_d[k]     = b_src[k];
      sum_d[k]   = s_src[k];
      sum_d[k][k*SEG +: SEG] = seg_res[k][SEG-1:0];
      carry_d[k] = seg_res[k][SEG];
    end

    zero_d = (sum_d[LAST] == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign io.in_ready  = adv;
  assign io.out_valid = valid_q[LAST];
  assign io.sum       = sum_q[LAST];
  assign io.cout      = carry_q[LAST];
  assign io.zero      = zero_q;
  // Overflow comes from the output-stage operand MSBs, so it holds with the rest of the result.
  assign io.ovf       = (a_q[LAST][MSB] == b_q[LAST][MSB]) &&
                        (sum_q[LAST][MSB] != a_q[LAST][MSB]);

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Scoreboard bench for pipelined_prefix_adder in W64/S16, W32/S8 and W16/S16 configurations.
module tb_pipelined_prefix_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipelined_prefix_adder_if #(.WIDTH(64)) if64 ();
  pipelined_prefix_adder_if #(.WIDTH(32)) if32 ();
  pipelined_prefix_adder_if #(.WIDTH(16)) if16 ();

  pipelined_prefix_adder #(.WIDTH(64), .SEG(16)) u64 (.clk(clk), .rst(rst), .io(if64));
  pipelined_prefix_adder #(.WIDTH(32), .SEG(8))  u32 (.clk(clk), .rst(rst), .io(if32));
  pipelined_prefix_adder #(.WIDTH(16), .SEG(16)) u16 (.clk(clk), .rst(rst), .io(if16));

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          t;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [1:0]  op;
    exp_t        e;
  } beat_t;

  int    tests_run    = 0;
  int    tests_failed = 0;
  int    cyc          = 0;
  exp_t  sb[$];
  beat_t beats[$];

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input int width, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic [1:0] op);
    logic [64:0] mask;
    logic [64:0] beff;
    logic [64:0] full;
    logic [64:0] c0;
    exp_t        e;
    mask   = (65'd1 << width) - 65'd1;
    beff   = (op[0] ? ~{1'b0, b} : {1'b0, b}) & mask;
    c0     = (op == 2'b00) ? 65'd0 : (op == 2'b01) ? 65'd1 : {64'd0, cin};
    full   = ({1'b0, a} & mask) + beff + c0;
    e.sum  = full[63:0] & mask[63:0];
    e.cout = full[width];
    e.ovf  = (a[width-1] == beff[width-1]) && (e.sum[width-1] != a[width-1]);
    e.zero = (e.sum == 64'd0);
    e.t    = 0;
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_in(input int sel, input logic iv, input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input logic [1:0] op, input logic ordy);
    case (sel)
      0: begin
        if64.in_valid = iv; if64.a = a; if64.b = b;
        if64.cin = ci; if64.op = op; if64.out_ready = ordy;
      end
      1: begin
        if32.in_valid = iv; if32.a = a[31:0]; if32.b = b[31:0];
        if32.cin = ci; if32.op = op; if32.out_ready = ordy;
      end
      default: begin
        if16.in_valid = iv; if16.a = a[15:0]; if16.b = b[15:0];
        if16.cin = ci; if16.op = op; if16.out_ready = ordy;
      end
    endcase
  endtask

  task automatic get_out(input int sel, output logic ov, output logic [63:0] s,
                         output logic co, output logic of, output logic z);
    case (sel)
      0: begin
        ov = if64.out_valid; s = if64.sum; co = if64.cout; of = if64.ovf; z = if64.zero;
      end
      1: begin
        ov = if32.out_valid; s = {32'd0, if32.sum}; co = if32.cout; of = if32.ovf; z = if32.zero;
      end
      default: begin
        ov = if16.out_valid; s = {48'd0, if16.sum}; co = if16.cout; of = if16.ovf; z = if16.zero;
      end
    endcase
  endtask

  function automatic logic rdy(input int sel);
    case (sel)
      0:       return if64.in_ready;
      1:       return if32.in_ready;
      default: return if16.in_ready;
    endcase
  endfunction

  task automatic add_beat(input logic [63:0] a, input logic [63:0] b, input logic cin,
                          input logic [1:0] op, input logic [63:0] sum, input logic cout,
                          input logic ovf, input logic zero);
    beat_t bt;
    bt.a = a; bt.b = b; bt.cin = cin; bt.op = op;
    bt.e.sum = sum; bt.e.cout = cout; bt.e.ovf = ovf; bt.e.zero = zero; bt.e.t = 0;
    beats.push_back(bt);
  endtask

  task automatic test_reset();
    logic        ov, co, of, z;
    logic [63:0] s;
    repeat (2) tick();
    get_out(0, ov, s, co, of, z);
    tests_run += 5;
    if (ov !== 1'b0)    begin tests_failed++; $display("[TB] FAIL reset out_valid: got %b want 0", ov); end
    if (s !== 64'd0)    begin tests_failed++; $display("[TB] FAIL reset sum: got %h want 0", s); end
    if (co !== 1'b0)    begin tests_failed++; $display("[TB] FAIL reset cout: got %b want 0", co); end
    if (of !== 1'b0)    begin tests_failed++; $display("[TB] FAIL reset ovf: got %b want 0", of); end
    if (z !== 1'b0)     begin tests_failed++; $display("[TB] FAIL reset zero: got %b want 0", z); end
    for (int sel = 0; sel < 3; sel++) begin
      tests_run++;
      if (rdy(sel) !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL reset in_ready[%0d]: got %b want 1", sel, rdy(sel));
      end
    end
  endtask

  task automatic test_directed(input int sel, input int stages, input string tag,
                               input logic release_rst);
    int          sent  = 0;
    int          got   = 0;
    int          guard = 0;
    logic        ov, co, of, z;
    logic [63:0] s;
    exp_t        e;
    sb.delete();
    while ((got < beats.size()) && (guard < 60)) begin
      tick();
      get_out(sel, ov, s, co, of, z);
      if (release_rst && (guard == 0)) rst = 1'b0;
      if (sent < beats.size())
        set_in(sel, 1'b1, beats[sent].a, beats[sent].b, beats[sent].cin, beats[sent].op, 1'b1);
      else
        set_in(sel, 1'b0, 64'd0, 64'd0, 1'b0, 2'b00, 1'b1);
      #1;
      if (release_rst && (guard == 0)) begin
        tests_run++;
        if (rdy(sel) !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL %s in_ready_after_reset: got %b want 1", tag, rdy(sel));
        end
      end
      if (ov) begin
        if (sb.size() == 0) begin
          tests_run++; tests_failed++;
          $display("[TB] FAIL %s spurious_out: got sum %h want no beat", tag, s);
        end else begin
          e = sb.pop_front();
          got++;
          tests_run += 5;
          if (s !== e.sum)  begin tests_failed++; $display("[TB] FAIL %s sum: got %h want %h", tag, s, e.sum); end
          if (co !== e.cout) begin tests_failed++; $display("[TB] FAIL %s cout: got %b want %b", tag, co, e.cout); end
          if (of !== e.ovf)  begin tests_failed++; $display("[TB] FAIL %s ovf: got %b want %b", tag, of, e.ovf); end
          if (z !== e.zero)  begin tests_failed++; $display("[TB] FAIL %s zero: got %b want %b", tag, z, e.zero); end
          if ((cyc - e.t) != stages) begin
            tests_failed++;
            $display("[TB] FAIL %s latency: got %0d want %0d", tag, cyc - e.t, stages);
          end
        end
      end
      if ((sent < beats.size()) && rdy(sel)) begin
        e   = beats[sent].e;
        e.t = cyc;
        sb.push_back(e);
        sent++;
      end
      guard++;
    end
    tests_run++;
    if (got != beats.size()) begin
      tests_failed++;
      $display("[TB] FAIL %s drain: got %0d beats want %0d", tag, got, beats.size());
    end
    set_in(sel, 1'b0, 64'd0, 64'd0, 1'b0, 2'b00, 1'b1);
    beats.delete();
  endtask

  task automatic test_back_to_back();
    logic [63:0] ba[6];
    logic [63:0] bb[6];
    logic [1:0]  bop[6];
    logic        bci[6];
    int          sent = 0, got = 0, guard = 0, stall_left = 0;
    logic        stall_started = 1'b0;
    logic        ordy;
    logic        ov, co, of, z;
    logic [63:0] s, held_s;
    exp_t        e;
    sb.delete();
    held_s = 64'd0;
    for (int i = 0; i < 6; i++) begin
      ba[i] = {$urandom, $urandom}; bb[i] = {$urandom, $urandom};
      bop[i] = 2'($urandom_range(0, 3)); bci[i] = 1'($urandom_range(0, 1));
    end
    while ((got < 6) && (guard < 60)) begin
      tick();
      get_out(0, ov, s, co, of, z);
      if (ov && !stall_started) begin
        stall_started = 1'b1;
        stall_left    = 3;
        held_s        = s;
      end
      ordy = (stall_left == 0);
      if (sent < 6) set_in(0, 1'b1, ba[sent], bb[sent], bci[sent], bop[sent], ordy);
      else          set_in(0, 1'b0, 64'd0, 64'd0, 1'b0, 2'b00, ordy);
      #1;
      if (stall_left > 0) begin
        tests_run++;
        if (rdy(0) !== 1'b0) begin
          tests_failed++; $display("[TB] FAIL b2b in_ready_stall: got %b want 0", rdy(0));
        end
        if (stall_left < 3) begin
          tests_run++;
          if ((ov !== 1'b1) || (s !== held_s)) begin
            tests_failed++;
            $display("[TB] FAIL b2b output_held: got valid %b sum %h want valid 1 sum %h", ov, s, held_s);
          end
        end
        stall_left--;
      end else if (ov) begin
        if (sb.size() == 0) begin
          tests_run++; tests_failed++;
          $display("[TB] FAIL b2b spurious_out: got sum %h want no beat", s);
        end else begin
          e = sb.pop_front();
          got++;
          tests_run += 4;
          if (s !== e.sum)   begin tests_failed++; $display("[TB] FAIL b2b sum: got %h want %h", s, e.sum); end
          if (co !== e.cout) begin tests_failed++; $display("[TB] FAIL b2b cout: got %b want %b", co, e.cout); end
          if (of !== e.ovf)  begin tests_failed++; $display("[TB] FAIL b2b ovf: got %b want %b", of, e.ovf); end
          if (z !== e.zero)  begin tests_failed++; $display("[TB] FAIL b2b zero: got %b want %b", z, e.zero); end
        end
      end
      if ((sent < 6) && rdy(0)) begin
        sb.push_back(model(64, ba[sent], bb[sent], bci[sent], bop[sent]));
        sent++;
      end
      guard++;
    end
    tests_run++;
    if (got != 6) begin
      tests_failed++; $display("[TB] FAIL b2b drain: got %0d beats want 6", got);
    end
    set_in(0, 1'b0, 64'd0, 64'd0, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic test_reset_inflight();
    int          sent = 0, guard = 0, leaked = 0;
    logic        seen = 1'b0;
    logic        ov, co, of, z;
    logic [63:0] s;
    sb.delete();
    while (!seen && (guard < 20)) begin
      tick();
      get_out(0, ov, s, co, of, z);
      seen = ov;
      set_in(0, (sent < 2), 64'h1234_5678_9abc_def0, 64'h0f0f_0f0f_0f0f_0f0f, 1'b0, 2'b00, !ov);
      #1;
      if ((sent < 2) && rdy(0)) sent++;
      guard++;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++; $display("[TB] FAIL rst_flight first_out: got none want out_valid");
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run += 3;
    if (if64.out_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL rst_flight async_valid: got %b want 0", if64.out_valid);
    end
    if (if64.in_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL rst_flight in_ready: got %b want 1", if64.in_ready);
    end
    if (if64.sum !== 64'd0) begin
      tests_failed++; $display("[TB] FAIL rst_flight sum: got %h want 0", if64.sum);
    end
    tick();
    rst = 1'b0;
    set_in(0, 1'b0, 64'd0, 64'd0, 1'b0, 2'b00, 1'b1);
    repeat (12) begin
      tick();
      get_out(0, ov, s, co, of, z);
      if (ov) leaked++;
    end
    tests_run += 2;
    if (leaked != 0) begin
      tests_failed++; $display("[TB] FAIL rst_flight leaked: got %0d beats want 0", leaked);
    end
    if (rdy(0) !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL rst_flight ready_after: got %b want 1", rdy(0));
    end
  endtask

  task automatic test_random(input int sel, input int width, input int n, input string tag);
    int          sent = 0, got = 0, guard = 0;
    logic        have = 1'b0, iv, ordy, prev_hold = 1'b0;
    logic [63:0] ca = 64'd0, cb = 64'd0, prev_s = 64'd0;
    logic        cci = 1'b0;
    logic [1:0]  cop = 2'b00;
    logic        ov, co, of, z;
    logic [63:0] s;
    exp_t        e;
    sb.delete();
    while ((got < n) && (guard < (n * 20 + 100))) begin
      tick();
      get_out(sel, ov, s, co, of, z);
      if (prev_hold) begin
        tests_run++;
        if ((ov !== 1'b1) || (s !== prev_s)) begin
          tests_failed++;
          $display("[TB] FAIL %s hold: got valid %b sum %h want valid 1 sum %h", tag, ov, s, prev_s);
        end
      end
      if (!have && (sent < n)) begin
        case ($urandom_range(0, 3))
          0:       ca = '1;
          1:       ca = 64'd1 << (width - 1);
          default: ca = {$urandom, $urandom};
        endcase
        case ($urandom_range(0, 3))
          0:       cb = 64'd0;
          1:       cb = '1;
          default: cb = {$urandom, $urandom};
        endcase
        cci  = 1'($urandom_range(0, 1));
        cop  = 2'($urandom_range(0, 3));
        have = 1'b1;
      end
      iv   = have && ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      set_in(sel, iv, ca, cb, cci, cop, ordy);
      #1;
      prev_hold = ov && !ordy;
      prev_s    = s;
      if (ov && ordy) begin
        if (sb.size() == 0) begin
          tests_run++; tests_failed++;
          $display("[TB] FAIL %s spurious_out: got sum %h want no beat", tag, s);
        end else begin
          e = sb.pop_front();
          got++;
          tests_run += 4;
          if (s !== e.sum)   begin tests_failed++; $display("[TB] FAIL %s sum: got %h want %h", tag, s, e.sum); end
          if (co !== e.cout) begin tests_failed++; $display("[TB] FAIL %s cout: got %b want %b", tag, co, e.cout); end
          if (of !== e.ovf)  begin tests_failed++; $display("[TB] FAIL %s ovf: got %b want %b", tag, of, e.ovf); end
          if (z !== e.zero)  begin tests_failed++; $display("[TB] FAIL %s zero: got %b want %b", tag, z, e.zero); end
        end
      end
      if (iv && rdy(sel)) begin
        sb.push_back(model(width, ca, cb, cci, cop));
        sent++;
        have = 1'b0;
      end
      guard++;
    end
    tests_run++;
    if (got != n) begin
      tests_failed++; $display("[TB] FAIL %s drain: got %0d beats want %0d", tag, got, n);
    end
    set_in(sel, 1'b0, 64'd0, 64'd0, 1'b0, 2'b00, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    for (int sel = 0; sel < 3; sel++) set_in(sel, 1'b0, 64'd0, 64'd0, 1'b0, 2'b00, 1'b1);

    test_reset();

    // ADD ignores cin; this beat is offered on the very cycle reset drops
    add_beat(64'd3, 64'd4, 1'b1, 2'b00, 64'd7, 1'b0, 1'b0, 1'b0);
    test_directed(0, 4, "post_reset", 1'b1);

    add_beat(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 1'b1);
    add_beat(64'd0, 64'd1, 1'b0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    add_beat(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b00, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    test_directed(0, 4, "w64", 1'b0);

    add_beat(64'h0000_00FF, 64'd0, 1'b1, 2'b10, 64'h0000_0100, 1'b0, 1'b0, 1'b0);
    add_beat(64'd5, 64'd5, 1'b0, 2'b11, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    test_directed(1, 4, "w32", 1'b0);

    add_beat(64'hFFFF, 64'd1, 1'b0, 2'b00, 64'd0, 1'b1, 1'b0, 1'b1);
    add_beat(64'h8000, 64'd1, 1'b1, 2'b11, 64'h7FFF, 1'b1, 1'b1, 1'b0);
    test_directed(2, 1, "w16", 1'b0);

    test_back_to_back();
    test_reset_inflight();

    test_random(0, 64, 300, "rnd64");
    test_random(1, 32, 300, "rnd32");
    test_random(2, 16, 300, "rnd16");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipelined_prefix_adder.md
PIPELINED_PREFIX_ADDER -- requirements
Module: pipelined_prefix_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter SEG, default 16, carry-segment width in bits; STAGES = WIDTH/SEG.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry/borrow-in, used by ADC/SBB only.
REQ-010 SHALL have port op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBB.
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry out of MSB (SUB/SBB: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  signed two's-complement overflow.
REQ-016 SHALL have port zero  output  1  sum == 0.

Function
REQ-017 SHALL compute b_eff = b for ADD/ADC, ~b for SUB/SBB; c0 = 0 ADD, 1 SUB, cin ADC/SBB.
REQ-018 SHALL compute result = a + b_eff + c0 modulo 2^WIDTH, cout = bit WIDTH of the full sum.
REQ-019 SHALL resolve exactly one SEG-bit segment per pipeline stage, segment k in stage k, using a prefix (generate/propagate) carry tree inside the segment; carry between segments registered.
REQ-020 SHALL carry unresolved upper operand bits and already-resolved lower sum bits alongside each stage (skew/deskew registers) so all bits of a beat emerge together.
REQ-021 SHALL deliver a result exactly STAGES cycles after an accepted beat when out_ready stays high (64/16: 4 cycles).
REQ-022 SHALL set ovf = (a[MSB] == b_eff[MSB]) and (sum[MSB] != a[MSB]); zero registered with sum.
REQ-023 SHALL advance the whole pipeline when adv = !out_valid || out_ready; in_ready = adv, combinational.
REQ-024 SHALL, when adv is low, hold every stage register, including sum/cout/ovf/zero/out_valid, stable.
REQ-025 SHALL accept one beat per cycle when in_valid && in_ready; empty slots propagate as bubbles (stage valid = 0).
REQ-026 SHALL ignore a, b, cin, op when in_valid is low; data registers of bubble slots are don't-care but out_valid = 0.
REQ-027 SHALL preserve beat order; no beat is dropped or duplicated under any out_ready pattern.
REQ-028 SHALL give a SEG = WIDTH configuration (STAGES = 1) one-cycle latency with identical handshake.
REQ-029 SHALL flag WIDTH % SEG != 0 or SEG < 1 as an elaboration error.

Reset
REQ-030 SHALL, on rst high, immediately clear all stage valid bits and out_valid to 0; sum, cout, ovf, zero to 0.
REQ-031 SHALL discard in-flight beats on reset mid-operation; none emerge after release.
REQ-032 SHALL drive in_ready = 1 during and after reset (pipe empty).
REQ-033 SHALL accept a beat in the first clock edge after rst deasserts.

Verification
REQ-034 SHALL cover: W64/S16 ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> after 4 cycles sum=0, cout=1, ovf=0, zero=1.
REQ-035 SHALL cover: SUB a=0, b=1 -> sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0, zero=0; ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> sum=0x8000_0000_0000_0000, ovf=1.
REQ-036 SHALL cover: 6 back-to-back beats, out_ready low 3 cycles once out_valid rises -> in_ready low same cycles, output held stable, all 6 results in order.
REQ-037 SHALL cover: rst asserted asynchronously with 2 beats in flight -> out_valid 0 before next edge, no result after release, in_ready 1.
REQ-038 SHALL cover: W32/S8 ADC a=0x0000_00FF, b=0, cin=1 -> sum=0x0000_0100, cout=0, 4-cycle latency; SBB a=5, b=5, cin=0 -> sum=0xFFFF_FFFF, cout=0.
REQ-039 SHALL cover: random op/operands against reference model, random in_valid/out_ready, W64/S16, W32/S8, W16/S16.
